// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
//   Request/result bundle between the EX stage and the iterative multiply/divide
//   unit.
//
//   Signals
//     start        request strobe from the pipeline
//     control      ALU control code (CONTROL_LENGTH bits)
//     alu_select   1 = float path; integer mult/div requests are ignored
//     operand_a    multiplicand / dividend
//     operand_b    multiplier / divisor
//     busy         operation in progress (pipeline stalls)
//     done         single-cycle pulse: hi/lo have just been updated
//     hi           product upper half / remainder
//     lo           product lower half / quotient
//     div_by_zero  last completed divide had a zero divisor
//
//   Modports
//     master : requester (pipeline / testbench)
//     slave  : muldiv_unit
// -----------------------------------------------------------------------------
interface muldiv_if #(
  parameter int CONTROL_LENGTH = 4,
  parameter int DATA_WIDTH     = 32
);
  logic                      start;
  logic [CONTROL_LENGTH-1:0] control;
  logic                      alu_select;
  logic [DATA_WIDTH-1:0]     operand_a;
  logic [DATA_WIDTH-1:0]     operand_b;
  logic                      busy;
  logic                      done;
  logic [DATA_WIDTH-1:0]     hi;
  logic [DATA_WIDTH-1:0]     lo;
  logic                      div_by_zero;

  modport master (
    output start, control, alu_select, operand_a, operand_b,
    input  busy, done, hi, lo, div_by_zero
  );

  modport slave (
    input  start, control, alu_select, operand_a, operand_b,
    output busy, done, hi, lo, div_by_zero
  );
endinterface

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//   Iterative multiply / divide unit that sits beside the integer ALU in EX and
//   owns the HI/LO result registers. One operand pair is taken per accepted
//   start; the operation runs one bit per cycle for DATA_WIDTH cycles while busy
//   is high, then done pulses for one cycle with hi/lo valid.
//
//   Multiply : shift-add into a 2W accumulator, one multiplier bit per cycle.
//   Divide   : restoring division, one quotient bit per cycle, W+1-bit trial
//              subtract. A zero divisor still runs W cycles and naturally
//              yields lo = all ones, hi = dividend.
//
//   Ports
//     clk    rising-edge clock
//     rst_n  asynchronous active-low reset (aborts any operation)
//     bus    muldiv_if.slave: start/control/alu_select/operand_a/operand_b in,
//            busy/done/hi/lo/div_by_zero out
//
//   Configuration
//     MULDIV_SIGNED_EN : when defined, operands are two's complement. Magnitudes
//                        are taken at accept and the result sign is fixed when
//                        hi/lo are written. Undefined: purely unsigned, no
//                        sign-fix logic. Latency is identical in both builds.
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int                        CONTROL_LENGTH = 4,
  parameter int                        DATA_WIDTH     = 32,
  parameter logic [CONTROL_LENGTH-1:0] CTRL_MULT      = 10,
  parameter logic [CONTROL_LENGTH-1:0] CTRL_DIV       = 11
) (
  input  logic     clk,
  input  logic     rst_n,
  muldiv_if.slave  bus
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(W);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [CW-1:0]    bit_cnt;
  logic             op_div;       // latched operation: 1 = divide
  logic             div_zero;     // latched: divisor was zero
  logic [W-1:0]     opnd;         // multiplicand (mult) or divisor (div) magnitude
  logic [2*W-1:0]   acc;          // mult: {partial product, multiplier}; div: {remainder, quotient}
  logic [W-1:0]     hi_q;
  logic [W-1:0]     lo_q;
  logic             dbz_q;

  logic             accept;
  logic             last_step;
  logic             req_div;
  logic [W-1:0]     a_mag;
  logic [W-1:0]     b_mag;

  logic [W:0]       mul_sum;
  logic [W:0]       div_trial;
  logic [W:0]       div_diff;
  logic [2*W-1:0]   acc_step;
  logic [W-1:0]     res_hi;
  logic [W-1:0]     res_lo;

`ifdef MULDIV_SIGNED_EN
  logic             a_sign;
  logic             b_sign;
  logic             neg_lo;       // mult: negate whole product; div: negate quotient
  logic             neg_hi;       // div: negate remainder
  logic             neg_lo_in;
  logic             neg_hi_in;
`endif

  // ---------------------------------------------------------------------------
  // Request qualification
  // ---------------------------------------------------------------------------
  assign req_div   = (bus.control == CTRL_DIV);
  assign accept    = bus.start && !bus.alu_select &&
                     ((bus.control == CTRL_MULT) || req_div) &&
                     (state != S_RUN);
  assign last_step = (state == S_RUN) && (bit_cnt == '0);

  // ---------------------------------------------------------------------------
  // Operand magnitudes (taken at accept)
  // ---------------------------------------------------------------------------
`ifdef MULDIV_SIGNED_EN
  assign a_sign = bus.operand_a[W-1];
  assign b_sign = bus.operand_b[W-1];
  assign a_mag  = a_sign ? (~bus.operand_a + 1'b1) : bus.operand_a;
  assign b_mag  = b_sign ? (~bus.operand_b + 1'b1) : bus.operand_b;

  // A zero divisor must leave lo as all ones, so the quotient is never negated
  // in that case; the remainder (= |dividend|) still takes the dividend's sign.
  assign neg_lo_in = req_div ? ((a_sign ^ b_sign) && (bus.operand_b != '0))
                             : (a_sign ^ b_sign);
  assign neg_hi_in = req_div ? a_sign : (a_sign ^ b_sign);
`else
  assign a_mag = bus.operand_a;
  assign b_mag = bus.operand_b;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable assigned in always_comb gets a default first so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      S_IDLE:  if (accept)    state_next = S_RUN;
      S_RUN:   if (last_step) state_next = S_DONE;
      S_DONE:  state_next = accept ? S_RUN : S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // One iteration of the shared datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    // Multiply: add multiplicand into the upper half when the current
    // multiplier bit (acc[0]) is set, then shift the whole accumulator right.
    mul_sum   = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
    // Divide: shift the next dividend bit into the remainder and trial-subtract.
    div_trial = {acc[2*W-1:W], acc[W-1]};
    div_diff  = div_trial - {1'b0, opnd};

    if (op_div) begin
      if (div_diff[W]) acc_step = {div_trial[W-1:0], acc[W-2:0], 1'b0};
      else             acc_step = {div_diff[W-1:0],  acc[W-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc[W-1:1]};
    end
  end

  // ---------------------------------------------------------------------------
  // Final result (sign fix only in the signed build)
  // ---------------------------------------------------------------------------
  always_comb begin
    res_hi = acc_step[2*W-1:W];
    res_lo = acc_step[W-1:0];
`ifdef MULDIV_SIGNED_EN
    if (op_div) begin
      if (neg_lo) res_lo = ~acc_step[W-1:0] + 1'b1;
      if (neg_hi) res_hi = ~acc_step[2*W-1:W] + 1'b1;
    end else if (neg_lo) begin
      {res_hi, res_lo} = ~acc_step + 1'b1;
    end
`endif
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= '0;
      op_div   <= 1'b0;
      div_zero <= 1'b0;
      opnd     <= '0;
      acc      <= '0;
`ifdef MULDIV_SIGNED_EN
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
`endif
    end else if (accept) begin
      bit_cnt  <= CW'(W - 1);
      op_div   <= req_div;
      div_zero <= (bus.operand_b == '0);
      opnd     <= req_div ? b_mag : a_mag;
      acc      <= {{W{1'b0}}, (req_div ? a_mag : b_mag)};
`ifdef MULDIV_SIGNED_EN
      neg_lo   <= neg_lo_in;
      neg_hi   <= neg_hi_in;
`endif
    end else if (state == S_RUN) begin
      bit_cnt  <= bit_cnt - 1'b1;
      acc      <= acc_step;
    end
  end

  // HI/LO and the divide-by-zero flag change only on the edge that enters DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q  <= '0;
      lo_q  <= '0;
      dbz_q <= 1'b0;
    end else if (last_step) begin
      hi_q  <= res_hi;
      lo_q  <= res_lo;
      dbz_q <= op_div && div_zero;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.busy        = (state == S_RUN);
  assign bus.done        = (state == S_DONE);
  assign bus.hi          = hi_q;
  assign bus.lo          = lo_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//   Self-checking bench for muldiv_unit (DATA_WIDTH = 32). Expected results come
//   from a behavioural model, are queued when a request is driven, and are
//   compared when the unit pulses done. Honours MULDIV_SIGNED_EN like the RTL.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  localparam int                CL        = 4;
  localparam int                W         = 32;
  localparam logic [CL-1:0]     CTRL_MULT = 4'd10;
  localparam logic [CL-1:0]     CTRL_DIV  = 4'd11;

  typedef struct packed {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic         dbz;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;
  exp_t sb_q[$];

  muldiv_if #(.CONTROL_LENGTH(CL), .DATA_WIDTH(W)) bus ();

  muldiv_unit #(
    .CONTROL_LENGTH(CL),
    .DATA_WIDTH    (W),
    .CTRL_MULT     (CTRL_MULT),
    .CTRL_DIV      (CTRL_DIV)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Behavioural reference
  function automatic exp_t model(input bit is_div, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [63:0] p;
`ifdef MULDIV_SIGNED_EN
    longint sa, sb, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
`endif
    e = '0;
    if (!is_div) begin
`ifdef MULDIV_SIGNED_EN
      p = 64'(sa * sb);
`else
      p = {32'h0, a} * {32'h0, b};
`endif
      e.hi = p[63:32];
      e.lo = p[31:0];
    end else if (b == '0) begin
      e.hi  = a;
      e.lo  = '1;
      e.dbz = 1'b1;
    end else begin
`ifdef MULDIV_SIGNED_EN
      q = sa / sb;
      r = sa % sb;
      p = 64'(q);
      e.lo = p[31:0];
      p = 64'(r);
      e.hi = p[31:0];
`else
      e.lo = a / b;
      e.hi = a % b;
`endif
    end
    return e;
  endfunction

  // Scoreboard: compare on every done pulse
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      if (sb_q.size() == 0) begin
        check("spurious_done", 64'(bus.done), 64'(0));
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("hi",  64'(bus.hi),          64'(e.hi));
        check("lo",  64'(bus.lo),          64'(e.lo));
        check("dbz", 64'(bus.div_by_zero), 64'(e.dbz));
      end
    end
  end

  // Drive one request and wait for its done. With b2b set, the request is
  // driven immediately (caller is sitting in a DONE cycle). With noisy set,
  // extra valid start pulses are driven during RUN and must be ignored.
  task automatic run_op(input logic [CL-1:0] ctl, input logic [W-1:0] a,
                        input logic [W-1:0] b, input bit b2b, input bit noisy);
    int cyc;
    if (!b2b) @(negedge clk);
    bus.start      = 1'b1;
    bus.control    = ctl;
    bus.alu_select = 1'b0;
    bus.operand_a  = a;
    bus.operand_b  = b;
    sb_q.push_back(model(ctl == CTRL_DIV, a, b));
    @(negedge clk);
    bus.start     = 1'b0;
    bus.operand_a = $urandom;
    bus.operand_b = $urandom;
    check("busy_after_accept", 64'(bus.busy), 64'(1));
    cyc = 1;
    while (!bus.done && cyc < 40) begin
      bus.start   = noisy && (cyc < 31);
      bus.control = noisy ? CTRL_DIV : CL'($urandom);
      @(negedge clk);
      cyc++;
    end
    bus.start = 1'b0;
    check("done_latency", 64'(cyc), 64'(33));
    check("busy_in_done", 64'(bus.busy), 64'(0));
  endtask

  // Drive an ignored request for one edge and confirm nothing started
  task automatic ignored_req(input string tag, input logic [CL-1:0] ctl, input logic sel);
    @(negedge clk);
    bus.start      = 1'b1;
    bus.control    = ctl;
    bus.alu_select = sel;
    bus.operand_a  = 32'd9;
    bus.operand_b  = 32'd9;
    @(negedge clk);
    bus.start      = 1'b0;
    bus.alu_select = 1'b0;
    check(tag, 64'(bus.busy), 64'(0));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int dones;
    bus.start      = 1'b0;
    bus.control    = '0;
    bus.alu_select = 1'b0;
    bus.operand_a  = '0;
    bus.operand_b  = '0;
    rst_n          = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy),        64'(0));
    check("rst_done", 64'(bus.done),        64'(0));
    check("rst_hi",   64'(bus.hi),          64'(0));
    check("rst_lo",   64'(bus.lo),          64'(0));
    check("rst_dbz",  64'(bus.div_by_zero), 64'(0));
    rst_n = 1'b1;

    // Main function
    run_op(CTRL_MULT, 32'd7,          32'd6,          1'b0, 1'b0);
    run_op(CTRL_MULT, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  1'b0, 1'b0);
    run_op(CTRL_MULT, 32'h1234_5678,  32'h9ABC_DEF0,  1'b0, 1'b0);
    run_op(CTRL_DIV,  32'd100,        32'd7,          1'b0, 1'b0);
    run_op(CTRL_DIV,  32'hFFFF_FFF9,  32'd2,          1'b0, 1'b0);
    run_op(CTRL_DIV,  32'h8000_0000,  32'hFFFF_FFFF,  1'b0, 1'b0);
    run_op(CTRL_DIV,  32'hFFFF_FFFF,  32'd1,          1'b0, 1'b0);

    // Divide by zero, flag held, then cleared by a mult
    run_op(CTRL_DIV,  32'd5,          32'd0,          1'b0, 1'b0);
    @(negedge clk);
    check("dbz_held", 64'(bus.div_by_zero), 64'(1));
    run_op(CTRL_MULT, 32'd3,          32'd3,          1'b0, 1'b0);
    run_op(CTRL_DIV,  32'hFFFF_FFF9,  32'd0,          1'b0, 1'b0);

    // Ignored requests
    ignored_req("ign_ctrl0",  4'd0,      1'b0);
    ignored_req("ign_float",  CTRL_MULT, 1'b1);

    // Start pulses during RUN are ignored
    run_op(CTRL_MULT, 32'd1000,       32'd1000,       1'b0, 1'b1);

    // Back-to-back: accept in the DONE cycle
    run_op(CTRL_DIV,  32'd12345,      32'd100,        1'b1, 1'b0);
    run_op(CTRL_MULT, 32'hDEAD_BEEF,  32'h0000_0010,  1'b1, 1'b0);

    // Random sweep
    for (int i = 0; i < 6; i++) begin
      run_op((i % 2 == 0) ? CTRL_MULT : CTRL_DIV, $urandom, $urandom_range(1, 5000), 1'b0, 1'b0);
    end

    // Reset mid-RUN aborts the operation
    @(negedge clk);
    bus.start     = 1'b1;
    bus.control   = CTRL_MULT;
    bus.operand_a = 32'd11;
    bus.operand_b = 32'd11;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(bus.busy), 64'(0));
    check("arst_done", 64'(bus.done), 64'(0));
    check("arst_hi",   64'(bus.hi),   64'(0));
    check("arst_lo",   64'(bus.lo),   64'(0));
    sb_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    dones = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.done) dones++;
    end
    check("no_done_after_reset", 64'(dones), 64'(0));
    check("scoreboard_empty", 64'(sb_q.size()), 64'(0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
